// File: rtl/tx_burst_seq_if.sv
// Handshake and parameter bus between a burst requester and tx_burst_seq.
// The requester drives start/abort and the burst parameters; the sequencer
// returns the registered bridge-driver controls and status.
interface tx_burst_seq_if;
  logic        start;
  logic        abort;
  logic [5:0]  half_in;
  logic [7:0]  div_in;
  logic [15:0] len_in;
  logic [5:0]  halfdata;
  logic        load;
  logic        bridge_rst;
  logic        bridge_clk;
  logic        busy;
  logic        done;

  modport master (
    output start, abort, half_in, div_in, len_in,
    input  halfdata, load, bridge_rst, bridge_clk, busy, done
  );

  modport slave (
    input  start, abort, half_in, div_in, len_in,
    output halfdata, load, bridge_rst, bridge_clk, busy, done
  );
endinterface

// File: rtl/tx_burst_seq.sv
// Burst sequencer for a bridge driver: presents a half-cycle count, strobes
// it in with a 2-cycle load pulse, releases the bridge reset and generates
// len periods of a divided tick clock, then pulses done. Every output is a
// flop, computed from the next state so it lines up with the state it
// belongs to.
module tx_burst_seq (
  input  logic          clkin,
  input  logic          reset,
  tx_burst_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    ARM    = 3'd3,
    BURST  = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  cap_div, cap_div_nx;
  logic [15:0] cap_len, cap_len_nx;
  logic [7:0]  div_cnt, div_cnt_nx;
  logic [15:0] tick_cnt, tick_cnt_nx;
  logic        strb_cnt, strb_cnt_nx;

  logic [5:0]  halfdata_q, halfdata_nx;
  logic        load_q, load_nx;
  logic        brst_q, brst_nx;
  logic        bclk_q, bclk_nx;
  logic        busy_q, busy_nx;
  logic        done_q, done_nx;

  // State, captured parameters, counters and registered outputs.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cap_div    <= '0;
      cap_len    <= '0;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      strb_cnt   <= 1'b0;
      halfdata_q <= '0;
      load_q     <= 1'b0;
      brst_q     <= 1'b1;
      bclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      cap_div    <= cap_div_nx;
      cap_len    <= cap_len_nx;
      div_cnt    <= div_cnt_nx;
      tick_cnt   <= tick_cnt_nx;
      strb_cnt   <= strb_cnt_nx;
      halfdata_q <= halfdata_nx;
      load_q     <= load_nx;
      brst_q     <= brst_nx;
      bclk_q     <= bclk_nx;
      busy_q     <= busy_nx;
      done_q     <= done_nx;
    end
  end

  // Next state, parameter capture, divider/tick counting and tick clock.
  always_comb begin
    state_nx    = state;
    cap_div_nx  = cap_div;
    cap_len_nx  = cap_len;
    halfdata_nx = halfdata_q;
    div_cnt_nx  = '0;
    tick_cnt_nx = '0;
    strb_cnt_nx = 1'b0;
    bclk_nx     = 1'b0;

    case (state)
      IDLE: begin
        // abort is not looked at here; start wins even if both are high.
        if (bus.start) begin
          state_nx    = SETUP;
          cap_div_nx  = bus.div_in;
          cap_len_nx  = bus.len_in;
          halfdata_nx = bus.half_in;
        end
      end
      SETUP: begin
        state_nx = bus.abort ? FINISH : STROBE;
      end
      STROBE: begin
        if (bus.abort) begin
          state_nx = FINISH;
        end else if (!strb_cnt) begin
          strb_cnt_nx = 1'b1;
        end else begin
          // A zero-length burst never releases the bridge reset.
          state_nx = (cap_len == 16'd0) ? FINISH : ARM;
        end
      end
      ARM: begin
        state_nx = bus.abort ? FINISH : BURST;
      end
      BURST: begin
        if (bus.abort) begin
          state_nx = FINISH;
        end else begin
          div_cnt_nx  = div_cnt + 8'd1;
          tick_cnt_nx = tick_cnt;
          bclk_nx     = bclk_q;
          if (div_cnt == cap_div) begin
            div_cnt_nx = '0;
            if (bclk_q) begin
              // Falling toggle; after the len-th rise this ends the burst low.
              bclk_nx = 1'b0;
              if (tick_cnt == cap_len) state_nx = FINISH;
            end else begin
              bclk_nx     = 1'b1;
              tick_cnt_nx = tick_cnt + 16'd1;
            end
          end
        end
      end
      FINISH: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // Counters and tick clock only live inside BURST.
    if (state_nx != BURST) begin
      div_cnt_nx  = '0;
      tick_cnt_nx = '0;
      bclk_nx     = 1'b0;
    end
  end

  // Output decode from the next state so every output is a plain flop.
  always_comb begin
    load_nx = (state_nx == STROBE);
    brst_nx = !((state_nx == ARM) || (state_nx == BURST));
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == FINISH);
  end

  assign bus.halfdata   = halfdata_q;
  assign bus.load       = load_q;
  assign bus.bridge_rst = brst_q;
  assign bus.bridge_clk = bclk_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_tx_burst_seq.sv
// Bench for tx_burst_seq: a table of burst scenarios run through one
// monitoring task, plus hand-written sequences for reset, idle abort,
// start/abort collision and start held across FINISH.
module tb_tx_burst_seq;

  logic clkin = 1'b0;
  logic reset = 1'b0;
  int   nchecks = 0;
  int   nerr = 0;

  tx_burst_seq_if bus();

  tx_burst_seq dut (
    .clkin (clkin),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clkin = ~clkin;

  // k = number of clkin edges after the edge that accepted start.
  typedef struct {
    int half;
    int div;
    int len;
    int ab_k;     // cycle after whose sample abort is raised (-1 none)
    int rep_k;    // cycle after whose sample start is re-pulsed (-1 none)
    int done_k;   // expected k of the done pulse
    int rises;    // expected bridge_clk rising toggles
    int low;      // expected cycles with bridge_rst low
    int period;   // expected rise-to-rise spacing (checked when rises >= 2)
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  k, rises, low, loads, load_first, dones, done_k, prev_rise, period;
    int  hd_bad, end_k;
    logic pb;
    rises = 0; low = 0; loads = 0; load_first = -1; dones = 0; done_k = -1;
    prev_rise = -1; period = 0; hd_bad = 0; end_k = -1; pb = 1'b0;

    @(negedge clkin);
    bus.start   = 1'b1;
    bus.half_in = 6'(v.half);
    bus.div_in  = 8'(v.div);
    bus.len_in  = 16'(v.len);
    @(posedge clkin);
    @(negedge clkin);
    bus.start = 1'b0;

    for (k = 0; k < 300; k++) begin
      if (bus.load) begin
        loads++;
        if (load_first < 0) load_first = k;
      end
      if (!bus.bridge_rst) low++;
      if (bus.bridge_clk && !pb) begin
        rises++;
        if (prev_rise >= 0) period = k - prev_rise;
        prev_rise = k;
      end
      pb = bus.bridge_clk;
      if (bus.done) begin
        dones++;
        done_k = k;
      end
      if (bus.halfdata != 6'(v.half)) hd_bad++;
      if (dones > 0 && !bus.busy) begin
        end_k = k;
        break;
      end
      bus.abort = (k == v.ab_k);
      if (k == v.rep_k) begin
        bus.start   = 1'b1;
        bus.half_in = 6'd40;
        bus.div_in  = 8'd0;
        bus.len_in  = 16'd1;
      end else begin
        bus.start   = 1'b0;
        bus.half_in = 6'(v.half);
      end
      @(negedge clkin);
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;

    chk($sformatf("v%0d end_k", idx), end_k, v.done_k + 1);
    chk($sformatf("v%0d done_k", idx), done_k, v.done_k);
    chk($sformatf("v%0d done_count", idx), dones, 1);
    chk($sformatf("v%0d load_cycles", idx), loads, 2);
    chk($sformatf("v%0d load_first", idx), load_first, 1);
    chk($sformatf("v%0d halfdata_bad", idx), hd_bad, 0);
    chk($sformatf("v%0d rises", idx), rises, v.rises);
    chk($sformatf("v%0d rst_low", idx), low, v.low);
    if (v.rises >= 2) chk($sformatf("v%0d period", idx), period, v.period);
    chk($sformatf("v%0d end_bclk", idx), int'(bus.bridge_clk), 0);
    chk($sformatf("v%0d end_brst", idx), int'(bus.bridge_rst), 1);
    chk($sformatf("v%0d end_halfdata", idx), int'(bus.halfdata), v.half);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " halfdata"}, int'(bus.halfdata), 0);
    chk({tag, " load"}, int'(bus.load), 0);
    chk({tag, " bridge_rst"}, int'(bus.bridge_rst), 1);
    chk({tag, " bridge_clk"}, int'(bus.bridge_clk), 0);
    chk({tag, " busy"}, int'(bus.busy), 0);
    chk({tag, " done"}, int'(bus.done), 0);
  endtask

  initial begin
    int dcnt, idle_k, rebusy;

    bus.start = 1'b0; bus.abort = 1'b0;
    bus.half_in = '0; bus.div_in = '0; bus.len_in = '0;

    vecs[0] = '{12, 1, 3, -1, -1, 16, 3, 13, 4};
    vecs[1] = '{ 7, 3, 0, -1, -1,  3, 0,  0, 0};
    vecs[2] = '{ 5, 0, 5, -1, -1, 14, 5, 11, 2};
    vecs[3] = '{63, 2, 2, -1, -1, 16, 2, 13, 6};
    vecs[4] = '{ 0, 0, 1, -1, -1,  6, 1,  3, 0};
    vecs[5] = '{ 9, 1, 3,  6, -1,  7, 1,  4, 0};
    vecs[6] = '{12, 1, 3, -1,  6, 16, 3, 13, 4};

    // Reset state.
    #12;
    chk_reset_outputs("rst");
    @(negedge clkin);
    reset = 1'b1;
    @(negedge clkin);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // abort in IDLE is ignored.
    @(negedge clkin);
    bus.abort = 1'b1;
    @(negedge clkin);
    chk("idle_abort busy", int'(bus.busy), 0);
    chk("idle_abort done", int'(bus.done), 0);
    bus.abort = 1'b0;

    // start and abort together: start wins, abort acts from SETUP.
    @(negedge clkin);
    bus.start = 1'b1; bus.abort = 1'b1;
    bus.half_in = 6'd21; bus.div_in = 8'd1; bus.len_in = 16'd3;
    @(negedge clkin);
    bus.start = 1'b0;
    chk("collide k0 busy", int'(bus.busy), 1);
    chk("collide k0 halfdata", int'(bus.halfdata), 21);
    @(negedge clkin);
    chk("collide k1 done", int'(bus.done), 1);
    chk("collide k1 load", int'(bus.load), 0);
    bus.abort = 1'b0;
    @(negedge clkin);
    chk("collide k2 busy", int'(bus.busy), 0);

    // start held high across FINISH restarts on the first IDLE cycle.
    @(negedge clkin);
    bus.start = 1'b1; bus.half_in = 6'd3; bus.div_in = 8'd0; bus.len_in = 16'd0;
    @(negedge clkin);
    idle_k = -1; rebusy = 0;
    for (int k = 0; k < 8; k++) begin
      if (idle_k < 0 && !bus.busy) idle_k = k;
      if (k == 5) rebusy = int'(bus.busy);
      @(negedge clkin);
    end
    bus.start = 1'b0;
    chk("held_start idle_k", idle_k, 4);
    chk("held_start rebusy", rebusy, 1);
    repeat (6) @(negedge clkin);
    chk("held_start settle busy", int'(bus.busy), 0);

    // Reset mid-burst truncates asynchronously with no done pulse.
    bus.start = 1'b1; bus.half_in = 6'd12; bus.div_in = 8'd1; bus.len_in = 16'd3;
    @(posedge clkin);
    @(negedge clkin);
    bus.start = 1'b0;
    repeat (6) @(negedge clkin);
    chk("midrst pre bclk", int'(bus.bridge_clk), 1);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("midrst");
    dcnt = 0;
    repeat (20) begin
      @(negedge clkin);
      if (bus.done) dcnt++;
    end
    chk("midrst done_count", dcnt, 0);

    // Release with start high: accepted at the first edge after release.
    bus.start = 1'b1; bus.len_in = 16'd0;
    reset = 1'b1;
    @(posedge clkin);
    #1 chk("release busy", int'(bus.busy), 1);
    @(negedge clkin);
    bus.start = 1'b0;
    repeat (6) @(negedge clkin);
    chk("release settle busy", int'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/tx_burst_seq.md
TX_BURST_SEQ -- requirements
Module: tx_burst_seq

Interface
REQ-001 SHALL have port: clkin  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  burst request, sampled in IDLE only.
REQ-004 SHALL have port: abort  input  1  terminate burst, sampled in every non-IDLE state.
REQ-005 SHALL have port: half_in  input  6  half-cycle count for the bridge driver, captured on accepted start.
REQ-006 SHALL have port: div_in  input  8  tick divider, captured on accepted start.
REQ-007 SHALL have port: len_in  input  16  burst length in bridge ticks, captured on accepted start.
REQ-008 SHALL have port: halfdata  output  6  registered half-cycle count presented to the bridge driver.
REQ-009 SHALL have port: load  output  1  active-high capture strobe to the bridge driver.
REQ-010 SHALL have port: bridge_rst  output  1  active-high reset to the bridge driver.
REQ-011 SHALL have port: bridge_clk  output  1  registered tick clock to the bridge driver.
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port: done  output  1  one-cycle completion or abort pulse.

Function
REQ-014 SHALL implement the states IDLE, SETUP, STROBE, ARM, BURST and FINISH; every output SHALL be registered.
REQ-015 IDLE: bridge_rst=1, bridge_clk=0, load=0; start=1 at edge N SHALL capture half_in, div_in and len_in, drive halfdata with the captured half_in at N, and enter SETUP.
REQ-016 SETUP SHALL last 1 cycle with load=0, so halfdata is stable one cycle before load rises.
REQ-017 STROBE SHALL hold load=1 for exactly 2 cycles (edges N+1, N+2) and then drive load=0.
REQ-018 After STROBE, a captured len of 0 SHALL go directly to FINISH with bridge_rst held at 1; any other len SHALL go to ARM.
REQ-019 ARM SHALL drive bridge_rst=0 for 1 cycle with bridge_clk=0, then enter BURST.
REQ-020 BURST: an 8-bit divider SHALL count 0..div; at terminal count the divider SHALL clear and bridge_clk SHALL toggle.
REQ-021 The resulting bridge_clk period SHALL be 2*(div+1) clkin cycles; div=0 SHALL toggle on every cycle.
REQ-022 A 16-bit tick counter SHALL increment on each bridge_clk rising toggle.
REQ-023 When the tick counter reaches len and bridge_clk is high, the next toggle SHALL drive bridge_clk low and the state SHALL enter FINISH.
REQ-024 The burst SHALL therefore contain exactly len complete bridge_clk periods, and its final level SHALL be 0.
REQ-025 FINISH SHALL last 1 cycle: bridge_rst=1, bridge_clk=0, done=1, counters cleared; the next state SHALL be IDLE.
REQ-026 abort=1 in SETUP, STROBE, ARM or BURST SHALL enter FINISH on the next edge, forcing load=0, bridge_clk=0 and bridge_rst=1 at that edge.
REQ-027 start while busy=1 SHALL be ignored; captured parameters SHALL NOT change during a burst.
REQ-028 abort while in IDLE SHALL be ignored.
REQ-029 start and abort together in IDLE SHALL be treated as start; abort then acts from SETUP onward.
REQ-030 start held high across FINISH SHALL begin a new burst only on the first IDLE cycle after FINISH.
REQ-031 halfdata SHALL retain the last captured value in IDLE.

Reset
REQ-032 reset=0 SHALL immediately force: state=IDLE, halfdata=0, load=0, bridge_rst=1, bridge_clk=0, busy=0, done=0, all counters 0.
REQ-033 Reset asserted mid-burst SHALL truncate bridge_clk immediately with no done pulse.
REQ-034 Deassertion of reset SHALL take effect at the first clkin edge after release, with start sampled at that edge.

Verification
REQ-035 SHALL cover: half_in=12, div=1, len=3, start pulse -> load high 2 cycles with halfdata=12; bridge_rst low; 3 bridge_clk periods of 4 cycles each; done pulse once; busy low afterward.
REQ-036 SHALL cover: len=0, start -> load strobe occurs, bridge_rst never deasserts, done pulses 4 cycles after start.
REQ-037 SHALL cover: div=0, len=5 -> bridge_clk period of 2 cycles and 5 rising toggles counted.
REQ-038 SHALL cover: abort asserted on the 2nd BURST tick -> bridge_rst=1 and bridge_clk=0 next edge; done pulses once; new start accepted afterward.
REQ-039 SHALL cover: start re-pulsed mid-burst with half_in=40 -> ignored; halfdata stays 12 and burst length is unchanged.
REQ-040 SHALL cover: reset driven low mid-burst -> all outputs at reset values without waiting for a clock edge; no done pulse.
